// File: rtl/lfsr_4_checker.sv
// lfsr_4_checker
//   Receive-side checker for the 4-bit x^4+x^3+1 pseudo-random sequence
//   (b[n+4] = b[n+3] ^ b[n], period 15). It self-synchronises to the
//   incoming bit stream, then flywheels on its own prediction, flagging and
//   counting mismatches.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   valid_i    bit_i is sampled on this edge; all state holds otherwise
//   bit_i      received sequence bit
//   clr_i      synchronous clear of err_cnt_o (wins over an increment)
//   locked_o   registered, high while in LOCK
//   err_o      registered one-cycle pulse per mismatch seen in LOCK
//   err_cnt_o  registered saturating count of mismatches seen in LOCK
//
// Build option
//   LFSR4_CHK_STATS_EN  when defined, the 16-bit error counter and its clear
//                       are built; otherwise err_cnt_o is tied to zero and
//                       clr_i is ignored.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_FILL | loading the first four bits into the history register
// S_HUNT | predicting from received bits, counting consecutive matches
// S_LOCK | flywheeling on the prediction, counting consecutive misses
module lfsr_4_checker #(
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_ERR = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        bit_i,
    input  logic        clr_i,
    output logic        locked_o,
    output logic        err_o,
    output logic [15:0] err_cnt_o
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_HUNT = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_ERR);

    state_t     state_q, state_d;
    logic [3:0] hist_q, hist_d;
    logic [1:0] fill_q, fill_d;
    logic [3:0] match_q, match_d;
    logic [3:0] miss_q, miss_d;
    logic       err_d;
    logic       cnt_inc;

    logic       pred;
    logic       hit;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;

    assign pred      = hist_q[0] ^ hist_q[3];
    assign hit       = (bit_i == pred);
    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FILL;
            hist_q   <= 4'd0;
            fill_q   <= 2'd0;
            match_q  <= 4'd0;
            miss_q   <= 4'd0;
            locked_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_o <= (state_d == S_LOCK);
            err_o    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_inc = 1'b0;
        if (valid_i) begin
            case (state_q)
                S_FILL: begin
                    hist_d = {hist_q[2:0], bit_i};
                    fill_d = fill_q + 2'd1;
                    if (fill_q == 2'd3) begin
                        state_d = S_HUNT;
                        match_d = 4'd0;
                    end
                end
                S_HUNT: begin
                    hist_d = {hist_q[2:0], bit_i};
                    // An all-zero history predicts zero forever; never count it.
                    if (hit && (hist_q != 4'd0)) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_TGT) begin
                            state_d = S_LOCK;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                S_LOCK: begin
                    if (hit) begin
                        hist_d = {hist_q[2:0], pred};
                        miss_d = 4'd0;
                    end else begin
                        err_d   = 1'b1;
                        cnt_inc = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc == UNLOCK_TGT) begin
                            // Leaving lock: resume tracking the line itself.
                            state_d = S_HUNT;
                            match_d = 4'd0;
                            hist_d  = {hist_q[2:0], bit_i};
                        end else begin
                            // Flywheel: a single bad bit must not poison the history.
                            hist_d = {hist_q[2:0], pred};
                        end
                    end
                end
                default: begin
                    state_d = S_FILL;
                    hist_d  = 4'd0;
                    fill_d  = 2'd0;
                    match_d = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end
    end

`ifdef LFSR4_CHK_STATS_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'd0;
        end else if (clr_i) begin
            err_cnt_q <= 16'd0;
        end else if (cnt_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_stats;

    assign unused_stats = clr_i ^ cnt_inc;
    assign err_cnt_o    = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_4_checker.sv
// Testbench for lfsr_4_checker: directed scenarios plus a randomized phase,
// all outputs checked every cycle against a queue-based reference model.
module tb_lfsr_4_checker;

    localparam int unsigned LOCK_CNT   = 8;
    localparam int unsigned UNLOCK_ERR = 3;
`ifdef LFSR4_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        bit_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_cnt_o;

    lfsr_4_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_ERR(UNLOCK_ERR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .bit_i    (bit_i),
        .clr_i    (clr_i),
        .locked_o (locked_o),
        .err_o    (err_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Generator stream from reset, period 15.
    bit pat [15] = '{1,0,0,0,1,1,1,1,0,1,0,1,1,0,0};
    int gi = 0;

    // Reference model: hq holds the last four history bits, oldest first.
    int          hq[$];
    int          m_mode;   // 0 fill, 1 hunt, 2 lock
    int          m_fill;
    int          m_match;
    int          m_miss;
    bit          m_locked;
    bit          m_err;
    logic [15:0] m_cnt;
    int          pulses;

    function automatic bit gen_bit();
        bit b;
        b  = pat[gi % 15];
        gi = gi + 1;
        return b;
    endfunction

    task automatic m_reset();
        hq       = '{0, 0, 0, 0};
        m_mode   = 0;
        m_fill   = 0;
        m_match  = 0;
        m_miss   = 0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_cnt    = 16'd0;
    endtask

    task automatic m_push(input int x);
        hq.push_back(x);
        void'(hq.pop_front());
    endtask

    task automatic m_step(input bit v, input bit b, input bit c);
        int pred;
        bit hit;
        bit nz;
        m_err = 1'b0;
        if (v) begin
            pred = hq[3] ^ hq[0];
            hit  = (int'(b) == pred);
            nz   = (hq[0] + hq[1] + hq[2] + hq[3]) != 0;
            if (m_mode == 0) begin
                m_push(int'(b));
                m_fill++;
                if (m_fill == 4) begin
                    m_mode  = 1;
                    m_match = 0;
                end
            end else if (m_mode == 1) begin
                m_push(int'(b));
                if (hit && nz) begin
                    m_match++;
                    if (m_match == int'(LOCK_CNT)) begin
                        m_mode = 2;
                        m_miss = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                if (hit) begin
                    m_push(pred);
                    m_miss = 0;
                end else begin
                    m_err = 1'b1;
                    m_miss++;
                    if (m_miss == int'(UNLOCK_ERR)) begin
                        m_mode  = 1;
                        m_match = 0;
                        m_push(int'(b));
                    end else begin
                        m_push(pred);
                    end
                end
            end
        end
        if (c) m_cnt = 16'd0;
        else if (STATS && m_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_locked = (m_mode == 2);
    endtask

    task automatic check(input string tag);
        n_cmp++;
        assert (locked_o === m_locked) else begin
            n_bad++;
            $error("FAIL %s locked_o observed=%0b expected=%0b", tag, locked_o, m_locked);
        end
        n_cmp++;
        assert (err_o === m_err) else begin
            n_bad++;
            $error("FAIL %s err_o observed=%0b expected=%0b", tag, err_o, m_err);
        end
        n_cmp++;
        assert (err_cnt_o === m_cnt) else begin
            n_bad++;
            $error("FAIL %s err_cnt_o observed=%0h expected=%0h", tag, err_cnt_o, m_cnt);
        end
    endtask

    // Called just after a rising edge; drives inputs, waits one edge, checks.
    task automatic step(input bit v, input bit b, input bit c, input string tag);
        valid_i = v;
        bit_i   = b;
        clr_i   = c;
        @(posedge clk);
        #1;
        m_step(v, b, c);
        check(tag);
        if (err_o) pulses++;
        valid_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    // Feeds clean stream bits until the DUT locks; returns valid bits used.
    task automatic feed_until_lock(input bit gap, input string tag, output int nbits);
        nbits = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, gen_bit(), 1'b0, tag);
            nbits++;
            if (locked_o) break;
            if (gap) step(1'b0, 1'b0, 1'b0, tag);
        end
        if (!locked_o) nbits = 99;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gi    = 0;
    endtask

    task automatic cmp_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        int nb;
        bit v, f, c, b;
        m_reset();
        pulses = 0;

        // Reset state.
        #2;
        check("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean sync: lock on valid bit 4+LOCK_CNT, then run to 100 bits.
        feed_until_lock(1'b0, "clean_sync", nb);
        cmp_int("clean_lock_bits", nb, 4 + int'(LOCK_CNT));
        for (int k = nb; k < 100; k++) step(1'b1, gen_bit(), 1'b0, "clean_run");
        cmp_int("clean_pulses", pulses, 0);
        cmp_int("clean_cnt", int'(err_cnt_o), 0);

        // Single flip in LOCK: one pulse, no follow-on errors, stays locked.
        pulses = 0;
        step(1'b1, ~gen_bit(), 1'b0, "single_flip");
        for (int k = 0; k < 20; k++) step(1'b1, gen_bit(), 1'b0, "single_after");
        cmp_int("single_pulses", pulses, 1);
        cmp_int("single_locked", int'(locked_o), 1);
        cmp_int("single_cnt", int'(err_cnt_o), STATS ? 1 : 0);

        // Burst of three flips: unlock on the third.
        step(1'b1, gen_bit(), 1'b1, "burst_clr");
        pulses = 0;
        for (int k = 0; k < 3; k++) step(1'b1, ~gen_bit(), 1'b0, "burst");
        cmp_int("burst_pulses", pulses, 3);
        cmp_int("burst_unlocked", int'(locked_o), 0);
        cmp_int("burst_cnt", int'(err_cnt_o), STATS ? 3 : 0);
        // The corrupt bit shifted in on the unlocking edge costs two HUNT
        // mismatches (clean bits 1 and 4) before eight clean matches.
        feed_until_lock(1'b0, "relock", nb);
        cmp_int("relock_bits", nb, 4 + int'(LOCK_CNT));

        // Stuck line.
        do_reset();
        for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 1'b0, "stuck");
        cmp_int("stuck_locked", int'(locked_o), 0);
        cmp_int("stuck_cnt", int'(err_cnt_o), 0);

        // Gapped valid.
        do_reset();
        feed_until_lock(1'b1, "gapped", nb);
        cmp_int("gapped_lock_bits", nb, 4 + int'(LOCK_CNT));
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, "idle_hold");

        // Clear colliding with a mismatch.
        step(1'b1, ~gen_bit(), 1'b0, "pre_clr_flip");
        for (int k = 0; k < 4; k++) step(1'b1, gen_bit(), 1'b0, "pre_clr_clean");
        step(1'b1, ~gen_bit(), 1'b1, "clr_collide");
        cmp_int("clr_collide_err", int'(err_o), 1);
        cmp_int("clr_collide_cnt", int'(err_cnt_o), 0);

        // Reset mid-LOCK, then relock.
        for (int k = 0; k < 5; k++) step(1'b1, gen_bit(), 1'b0, "pre_reset");
        do_reset();
        feed_until_lock(1'b0, "post_reset", nb);
        cmp_int("post_reset_lock_bits", nb, 4 + int'(LOCK_CNT));

        // Randomized: gapped valid, sparse flips and clears, model-checked.
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 40) == 0);
            b = v ? (gen_bit() ^ f) : 1'($urandom_range(0, 1));
            step(v, b, c, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
